game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level round controller for the Simon (Genius) game. It sequences the per-state modules (idle, sequence display, player input, win, lose) by driving exactly one one-hot enable at a time. It tracks round length, the expected-press index and the score, and enforces a player-input timeout. It sits between the idle module's completion output and the display/input/result modules, and owns the game's top-level state.

## Interface
Parameters:
- TIMEOUT_TICKS, default 3000: number of `i_tick` pulses allowed between presses in INPUT before the game is lost.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: system clock. This is the block's only clock.
- `i_rst_n`, in, 1: reset. Synchronous and active-low.
- `i_idle_done`, in, 1: start accepted by the idle module. Sampled only in IDLE.
- `i_level`, in, 2: difficulty. Latched when `i_idle_done` is accepted.
- `i_show_done`, in, 1: display module finished showing the current sequence. Sampled only in SHOW.
- `i_btn_valid`, in, 1: one-cycle pulse per player press. Sampled only in INPUT.
- `i_btn_match`, in, 1: press matched the expected colour. Qualified by `i_btn_valid`.
- `i_tick`, in, 1: one-cycle timebase pulse for the timeout.
- `i_ack`, in, 1: result acknowledged. Sampled only in WIN and LOSE.
- `o_en_idle`, `o_en_show`, `o_en_input`, `o_en_win`, `o_en_lose`, out, 1 each: one-hot state-module enables.
- `o_add_color`, out, 1: one-cycle pulse requesting that the sequence generator append one colour.
- `o_state`, out, 3: state code. IDLE=0, EXTEND=1, SHOW=2, INPUT=3, WIN=4, LOSE=5.
- `o_round`, out, 6: current sequence length, range 0..32.
- `o_step`, out, 6: index of the next expected press, range 0..31.
- `o_score`, out, 6: rounds completed.

## Operation
- Reset (`i_rst_n`=0 at a clock edge): state IDLE, `o_en_idle`=1, all other enables 0, `o_add_color`=0, `o_round`=0, `o_step`=0, `o_score`=0, timer=0, target=8.
- Enables and `o_add_color` are decoded from the state register (Moore). Exactly one enable is high in every cycle.
- IDLE: on `i_idle_done`=1:
  - target is set to 8×(`i_level`+1), giving 8/16/24/32.
  - `o_round`←1, `o_step`←0, `o_score`←0.
  - Go to EXTEND.
- EXTEND: lasts exactly one cycle with `o_add_color`=1, then goes to SHOW. `o_step` is cleared.
- SHOW: waits for `i_show_done`, then goes to INPUT with the timer cleared.
- INPUT, on `i_btn_valid`=1:
  - `i_btn_match`=0: go to LOSE.
  - Match and `o_step` < `o_round`−1: `o_step`+1, timer cleared, stay in INPUT.
  - Match and `o_step` = `o_round`−1: `o_score`←`o_round`. If `o_round`=target, go to WIN. Otherwise `o_round`+1 and go to EXTEND.
- INPUT, timeout: on `i_tick`=1 with timer = TIMEOUT_TICKS−1 and no `i_btn_valid` in the same cycle, go to LOSE. Otherwise each `i_tick` increments the timer.
- WIN and LOSE: `o_round`, `o_step` and `o_score` hold their values for display. On `i_ack`=1, go to IDLE; counters keep their values until the next start.
- Ignored inputs:
  - `i_btn_valid` outside INPUT.
  - `i_show_done` outside SHOW.
  - `i_idle_done` outside IDLE.
  - `i_ack` outside WIN and LOSE.
  - `i_tick` outside INPUT (the timer holds).
- Width rules:
  - Timer width is $clog2(TIMEOUT_TICKS).
  - `o_round` never exceeds target (≤ 32). No wrap-around is possible.
  - `i_level` changes after latching have no effect until the next start.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N (i.e. during cycle N+1).
- Start to first display: `i_idle_done` at edge N gives EXTEND with `o_round`=1 and `o_add_color`=1 in cycle N+1, and SHOW in cycle N+2.
- Last correct press at edge N (not final round): EXTEND in N+1 with the incremented `o_round`, SHOW in N+2.
- Simultaneous events:
  - `i_btn_valid` takes priority over a timeout expiring in the same cycle. The press is evaluated and the timer is cleared.
  - `i_rst_n`=0 overrides everything.
- Reset mid-operation: a reset asserted in any state returns all outputs to their reset values after the next edge.
- `i_btn_valid` held high for k cycles counts as k presses. Debouncing is the input module's job.

## Test plan
- **Reset:** hold `i_rst_n`=0 for 2 cycles from any state → `o_state`=0, `o_en_idle`=1, `o_round`=`o_step`=`o_score`=0, `o_add_color`=0.
- **Full win, level 0:** answer every round correctly → 8 `o_add_color` pulses, `o_round` steps 1..8, then WIN with `o_score`=8. `i_ack` returns to IDLE the next cycle.
- **Wrong press:** in round 3, press step 0 with match and step 1 with mismatch → LOSE, `o_score`=2, `o_round`=3, `o_step`=1.
- **Timeout race (TIMEOUT_TICKS=4):**
  - No press and 4 ticks → LOSE after the 4th tick's edge.
  - Separately, a matching press on the same cycle as the 4th tick → remains in play and the timer restarts at 0.
- **Stray inputs:** `i_btn_valid` during SHOW and `i_ack` during INPUT → no state or counter change. Reset asserted in INPUT at round 5 → IDLE with counters cleared.
- **Level 3:** start with `i_level`=3 → target 32. After 32 correct rounds → WIN with `o_score`=32 and no overflow in `o_round`.

Source files
------------

// File: rtl/game_sequencer.sv
// Simon round controller: one-hot state-module enables, round/step/score tracking, input timeout.
// All state registered; outputs valid the cycle after the sampling edge; no backpressure (inputs are pulses).
module game_sequencer #(
    parameter int TIMEOUT_TICKS = 3000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_idle_done,
    input  logic [1:0] i_level,
    input  logic       i_show_done,
    input  logic       i_btn_valid,
    input  logic       i_btn_match,
    input  logic       i_tick,
    input  logic       i_ack,
    output logic       o_en_idle,
    output logic       o_en_show,
    output logic       o_en_input,
    output logic       o_en_win,
    output logic       o_en_lose,
    output logic       o_add_color,
    output logic [2:0] o_state,
    output logic [5:0] o_round,
    output logic [5:0] o_step,
    output logic [5:0] o_score
);
    localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXTEND = 3'd1,
        S_SHOW   = 3'd2,
        S_INPUT  = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    round_q, round_d;
    logic [5:0]    step_q, step_d;
    logic [5:0]    score_q, score_d;
    logic [5:0]    target_q, target_d;
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            step_q   <= '0;
            score_q  <= '0;
            target_q <= 6'd8;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            step_q   <= step_d;
            score_q  <= score_d;
            target_q <= target_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        step_d   = step_q;
        score_d  = score_q;
        target_d = target_q;
        timer_d  = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_idle_done) begin
                    target_d = {{1'b0, i_level} + 3'd1, 3'b000};
                    round_d  = 6'd1;
                    step_d   = '0;
                    score_d  = '0;
                    state_d  = S_EXTEND;
                end
            end
            S_EXTEND: begin
                step_d  = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (i_show_done) begin
                    timer_d = '0;
                    state_d = S_INPUT;
                end
            end
            S_INPUT: begin
                // A press wins over a timeout landing on the same cycle.
                if (i_btn_valid) begin
                    timer_d = '0;
                    if (!i_btn_match) begin
                        state_d = S_LOSE;
                    end else if (step_q != round_q - 6'd1) begin
                        step_d = step_q + 6'd1;
                    end else begin
                        score_d = round_q;
                        if (round_q == target_q) begin
                            state_d = S_WIN;
                        end else begin
                            round_d = round_q + 6'd1;
                            state_d = S_EXTEND;
                        end
                    end
                end else if (i_tick) begin
                    if (timer_q == TIMER_LAST) begin
                        state_d = S_LOSE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (i_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // EXTEND keeps the display side enabled so exactly one enable is always high.
    always_comb begin
        o_en_idle   = (state_q == S_IDLE);
        o_en_show   = (state_q == S_SHOW) || (state_q == S_EXTEND);
        o_en_input  = (state_q == S_INPUT);
        o_en_win    = (state_q == S_WIN);
        o_en_lose   = (state_q == S_LOSE);
        o_add_color = (state_q == S_EXTEND);
    end

    assign o_state = state_q;
    assign o_round = round_q;
    assign o_step  = step_q;
    assign o_score = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized play against a rule-level model.
module tb_game_sequencer;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n, idle_done, show_done, btn_valid, btn_match, tick, ack;
    logic [1:0] level;
    logic       en_idle, en_show, en_input, en_win, en_lose, add_color;
    logic [2:0] state;
    logic [5:0] round, step, score;

    int n_checks = 0;
    int n_errors = 0;
    int add_cnt  = 0;

    // rule-level model of the game
    int m_state, m_round, m_step, m_score, m_target, m_timer;

    game_sequencer #(.TIMEOUT_TICKS(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_idle_done(idle_done), .i_level(level),
        .i_show_done(show_done), .i_btn_valid(btn_valid), .i_btn_match(btn_match),
        .i_tick(tick), .i_ack(ack),
        .o_en_idle(en_idle), .o_en_show(en_show), .o_en_input(en_input),
        .o_en_win(en_win), .o_en_lose(en_lose), .o_add_color(add_color),
        .o_state(state), .o_round(round), .o_step(step), .o_score(score)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_en(input int s);
        case (s)
            0: return 5'b00001;
            1, 2: return 5'b00010;
            3: return 5'b00100;
            4: return 5'b01000;
            default: return 5'b10000;
        endcase
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_state = 0; m_round = 0; m_step = 0; m_score = 0; m_timer = 0; m_target = 8;
        end else begin
            case (m_state)
                0: if (idle_done) begin
                    m_target = 8 * (int'(level) + 1);
                    m_round = 1; m_step = 0; m_score = 0; m_state = 1;
                end
                1: begin m_step = 0; m_state = 2; end
                2: if (show_done) begin m_timer = 0; m_state = 3; end
                3: if (btn_valid) begin
                    m_timer = 0;
                    if (!btn_match) m_state = 5;
                    else if (m_step < m_round - 1) m_step++;
                    else begin
                        m_score = m_round;
                        if (m_round == m_target) m_state = 4;
                        else begin m_round++; m_state = 1; end
                    end
                end else if (tick) begin
                    if (m_timer == T - 1) m_state = 5;
                    else m_timer++;
                end
                default: if (ack) m_state = 0;
            endcase
        end
    endtask

    // Apply the currently driven inputs for one edge, then release the pulses.
    task automatic cyc();
        @(posedge clk);
        #1;
        model_update();
        if (add_color === 1'b1) add_cnt++;
        idle_done = 0; show_done = 0; btn_valid = 0; btn_match = 0; tick = 0; ack = 0;
    endtask

    task automatic start(input logic [1:0] lvl);
        idle_done = 1; level = lvl; cyc();
    endtask

    // From EXTEND: show the sequence, then answer all r presses correctly.
    task automatic play_round(input int r);
        cyc();
        show_done = 1; cyc();
        for (int k = 0; k < r; k++) begin
            btn_valid = 1; btn_match = 1; cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 0; cyc(); cyc();
        rst_n = 1;
        n_checks++;
        if (state !== 3'd0 || {en_lose, en_win, en_input, en_show, en_idle} !== 5'b00001
            || add_color !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d en=%b add=%b, want 0 00001 0", state,
                     {en_lose, en_win, en_input, en_show, en_idle}, add_color);
        end
        n_checks++;
        if (round !== 6'd0 || step !== 6'd0 || score !== 6'd0) begin
            n_errors++;
            $display("FAIL reset_counters: round=%0d step=%0d score=%0d, want 0 0 0", round, step, score);
        end
    endtask

    task automatic test_win_level0();
        int bad = 0;
        add_cnt = 0;
        start(2'd0);
        for (int r = 1; r <= 8; r++) begin
            if (state !== 3'd1 || add_color !== 1'b1 || round !== 6'(r)) bad++;
            cyc();
            if (state !== 3'd2 || add_color !== 1'b0) bad++;
            show_done = 1; cyc();
            for (int k = 0; k < r; k++) begin
                btn_valid = 1; btn_match = 1; cyc();
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL win0_rounds: %0d round/extend mismatches, want 0", bad);
        end
        n_checks++;
        if (state !== 3'd4 || en_win !== 1'b1 || score !== 6'd8 || round !== 6'd8) begin
            n_errors++;
            $display("FAIL win0_final: state=%0d en_win=%b score=%0d round=%0d, want 4 1 8 8",
                     state, en_win, score, round);
        end
        n_checks++;
        if (add_cnt != 8) begin
            n_errors++;
            $display("FAIL win0_pulses: got %0d add_color pulses, want 8", add_cnt);
        end
        ack = 1; cyc();
        n_checks++;
        if (state !== 3'd0 || en_idle !== 1'b1 || score !== 6'd8) begin
            n_errors++;
            $display("FAIL win0_ack: state=%0d en_idle=%b score=%0d, want 0 1 8", state, en_idle, score);
        end
    endtask

    task automatic test_wrong_press();
        start(2'd0);
        play_round(1);
        play_round(2);
        cyc();
        show_done = 1; cyc();
        btn_valid = 1; btn_match = 1; cyc();
        btn_valid = 1; btn_match = 0; cyc();
        n_checks++;
        if (state !== 3'd5 || en_lose !== 1'b1 || score !== 6'd2 || round !== 6'd3 || step !== 6'd1) begin
            n_errors++;
            $display("FAIL wrong_press: state=%0d en_lose=%b score=%0d round=%0d step=%0d, want 5 1 2 3 1",
                     state, en_lose, score, round, step);
        end
        ack = 1; cyc();
    endtask

    task automatic test_timeout();
        start(2'd1);
        cyc();
        show_done = 1; cyc();
        for (int i = 0; i < T - 1; i++) begin tick = 1; cyc(); end
        n_checks++;
        if (state !== 3'd3) begin
            n_errors++;
            $display("FAIL timeout_early: state=%0d after %0d ticks, want 3", state, T - 1);
        end
        tick = 1; cyc();
        n_checks++;
        if (state !== 3'd5) begin
            n_errors++;
            $display("FAIL timeout_expire: state=%0d after %0d ticks, want 5", state, T);
        end
        ack = 1; cyc();
        // press coinciding with the expiring tick
        start(2'd0);
        play_round(1);
        cyc();
        show_done = 1; cyc();
        for (int i = 0; i < T - 1; i++) begin tick = 1; cyc(); end
        tick = 1; btn_valid = 1; btn_match = 1; cyc();
        n_checks++;
        if (state !== 3'd3 || step !== 6'd1) begin
            n_errors++;
            $display("FAIL timeout_race: state=%0d step=%0d, want 3 1", state, step);
        end
        for (int i = 0; i < T - 1; i++) begin tick = 1; cyc(); end
        n_checks++;
        if (state !== 3'd3) begin
            n_errors++;
            $display("FAIL timeout_restart: state=%0d, want 3 (timer restarted)", state);
        end
        tick = 1; cyc();
        n_checks++;
        if (state !== 3'd5) begin
            n_errors++;
            $display("FAIL timeout_after_race: state=%0d, want 5", state);
        end
        ack = 1; cyc();
    endtask

    task automatic test_stray();
        start(2'd2);
        cyc();
        btn_valid = 1; btn_match = 0; idle_done = 1; ack = 1; cyc();
        n_checks++;
        if (state !== 3'd2 || round !== 6'd1 || step !== 6'd0 || score !== 6'd0) begin
            n_errors++;
            $display("FAIL stray_show: state=%0d round=%0d step=%0d score=%0d, want 2 1 0 0",
                     state, round, step, score);
        end
        show_done = 1; cyc();
        ack = 1; show_done = 1; idle_done = 1; cyc();
        n_checks++;
        if (state !== 3'd3 || round !== 6'd1 || step !== 6'd0) begin
            n_errors++;
            $display("FAIL stray_input: state=%0d round=%0d step=%0d, want 3 1 0", state, round, step);
        end
        btn_valid = 1; btn_match = 1; cyc();
        for (int r = 2; r <= 4; r++) play_round(r);
        cyc();
        show_done = 1; cyc();
        btn_valid = 1; btn_match = 1; cyc();
        n_checks++;
        if (state !== 3'd3 || round !== 6'd5 || step !== 6'd1 || score !== 6'd4) begin
            n_errors++;
            $display("FAIL stray_round5: state=%0d round=%0d step=%0d score=%0d, want 3 5 1 4",
                     state, round, step, score);
        end
        rst_n = 0; cyc();
        rst_n = 1;
        n_checks++;
        if (state !== 3'd0 || en_idle !== 1'b1 || round !== 6'd0 || step !== 6'd0 || score !== 6'd0) begin
            n_errors++;
            $display("FAIL stray_reset: state=%0d en_idle=%b round=%0d step=%0d score=%0d, want 0 1 0 0 0",
                     state, en_idle, round, step, score);
        end
    endtask

    task automatic test_level3();
        add_cnt = 0;
        start(2'd3);
        level = 2'd0;  // later level changes must not matter
        for (int r = 1; r <= 32; r++) play_round(r);
        n_checks++;
        if (state !== 3'd4 || score !== 6'd32 || round !== 6'd32 || add_cnt != 32) begin
            n_errors++;
            $display("FAIL level3_win: state=%0d score=%0d round=%0d pulses=%0d, want 4 32 32 32",
                     state, score, round, add_cnt);
        end
        ack = 1; cyc();
    endtask

    task automatic test_random();
        int bad_state = 0, bad_cnt = 0;
        rst_n = 0; cyc(); rst_n = 1;
        for (int c = 0; c < 6000; c++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            idle_done = ($urandom_range(0, 3) == 0);
            level     = 2'($urandom_range(0, 3));
            show_done = ($urandom_range(0, 2) == 0);
            btn_valid = ($urandom_range(0, 1) == 0);
            btn_match = ($urandom_range(0, 15) != 0);
            tick      = ($urandom_range(0, 2) == 0);
            ack       = ($urandom_range(0, 3) == 0);
            cyc();
            rst_n = 1;
            if (state !== 3'(m_state) || {en_lose, en_win, en_input, en_show, en_idle} !== exp_en(m_state)
                || add_color !== (m_state == 1)) begin
                bad_state++;
                if (bad_state <= 3)
                    $display("FAIL rand_state: cycle %0d state=%0d en=%b add=%b, want %0d %b %b", c, state,
                             {en_lose, en_win, en_input, en_show, en_idle}, add_color, m_state,
                             exp_en(m_state), m_state == 1);
            end
            if (round !== 6'(m_round) || step !== 6'(m_step) || score !== 6'(m_score)) begin
                bad_cnt++;
                if (bad_cnt <= 3)
                    $display("FAIL rand_counters: cycle %0d round=%0d step=%0d score=%0d, want %0d %0d %0d",
                             c, round, step, score, m_round, m_step, m_score);
            end
        end
        n_checks++;
        if (bad_state != 0) n_errors++;
        n_checks++;
        if (bad_cnt != 0) n_errors++;
    endtask

    initial begin
        rst_n = 0; idle_done = 0; level = 0; show_done = 0;
        btn_valid = 0; btn_match = 0; tick = 0; ack = 0;
        m_state = 0; m_round = 0; m_step = 0; m_score = 0; m_target = 8; m_timer = 0;
        test_reset();
        test_win_level0();
        test_wrong_press();
        test_timeout();
        test_stray();
        test_level3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
